count_frame_packer: RTL
=======================

Name: count_frame_packer

Overview:
- Sits between the nine per-channel batch counters and the byte-serial UART transmitter.
- On each batch_done pulse it snapshots all channel counts and emits one framed packet over a valid/ready byte handshake: sync, sequence/status, nine count bytes, XOR checksum.
- Replaces free-running mux shuffling, so the host can detect frame boundaries, lost frames and corrupted bytes.

Parameters:
- NUM_CH, 9, number of count channels per frame.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- batch_done  input  1  single-cycle pulse: counts valid this cycle.
- counts  input  NUM_CH*8  flat count bus; channel k at [k*8 +: 8]. Order: A, B, BP, AP, AB, ABP, APB, APBP, ABBP.
- tx_ready  input  1  transmitter can accept a byte this cycle.
- tx_valid  output  1  tx_data holds a byte to send.
- tx_data  output  8  frame byte.
- busy  output  1  frame in progress (state SEND).
- frame_done  output  1  one-cycle pulse after the checksum byte is accepted.
- dropped  output  8  saturating count of batches discarded because a frame was still in flight.

Behaviour:
- Reset (async, rst_n=0) drives these outputs and registers to 0:
  - tx_valid, tx_data, busy, frame_done, dropped.
  - Sequence counter, overrun flag, byte index and shadow registers.
  - State goes to IDLE.
- Byte transfer occurs on a rising clk when tx_valid=1 and tx_ready=1.
- While tx_valid=1 and tx_ready=0, tx_data must hold stable.
- Frame layout, NUM_CH+3 bytes; index 0..NUM_CH+2:
  - Index 0: SYNC_BYTE.
  - Index 1: {ovr, seq[6:0]}.
  - Index 2..NUM_CH+1: shadow[0..NUM_CH-1].
  - Index NUM_CH+2: CHK, the XOR of bytes 1..NUM_CH+1.
- States:
  - IDLE: tx_valid=0, busy=0. On batch_done, capture counts into the shadow registers and capture {ovr, seq}. Next cycle: SEND, index=0, tx_valid=1, tx_data=SYNC_BYTE. Latency is batch_done at cycle N to first byte valid at N+1.
  - SEND: busy=1. On each handshake the index increments and tx_data loads the next byte in the following cycle. tx_valid stays high between bytes, with no gap cycles.
  - SEND, last byte: when the CHK byte is accepted, pulse frame_done for one cycle. seq increments, wrapping 127 to 0. ovr clears. Return to IDLE, or directly to a new SEND (see simultaneity below).
- CHK accumulates incrementally as bytes 1..NUM_CH+1 are issued; no combinational XOR across the whole frame.
- Shadow registers are the only source of count bytes. Input count changes during SEND never affect the frame in flight.
- Overrun: batch_done during SEND, other than in the cycle the CHK byte is accepted, is discarded.
  - dropped increments, saturating at 255.
  - A sticky pending flag sets; it becomes ovr=1 in the next frame transmitted.
- Simultaneous batch_done and CHK acceptance counts as a new frame, not an overrun:
  - Snapshot is taken that cycle.
  - frame_done pulses.
  - Next cycle: SEND, SYNC_BYTE valid, busy stays 1.
  - The new frame's seq is the incremented value. Its ovr reflects only drops before that cycle.
- tx_ready with tx_valid=0 has no effect.
- Reset mid-frame aborts the frame immediately: tx_valid=0 asynchronously and no frame_done. Sequence restarts at 0.
- dropped is never cleared except by reset.

Test Plan:
- Basic frame: reset release, tx_ready=1 constant, counts ch0..ch8 = 1..9, one batch_done pulse at cycle N.
  - Required: bytes A5,00,01,02,...,09,CHK=0x01 on cycles N+1..N+12.
  - Required: frame_done at N+13, busy low at N+13.
- Backpressure: same counts, tx_ready toggled 1,0,0,1 repeating.
  - Required: every byte held stable while tx_ready=0; identical byte sequence.
  - Required: counts changed to all 0xFF mid-frame do not alter payload.
- Overrun: second batch_done 3 cycles into frame 0, with tx_ready=1.
  - Required: dropped=1.
  - Required: next frame (after a third batch_done) seq byte = 0x81.
  - Required: the frame after that has seq byte 0x02.
- Back-to-back: batch_done asserted exactly in the cycle CHK is accepted.
  - Required: dropped unchanged, frame_done pulses.
  - Required: next cycle tx_data=A5 with seq byte 0x01, busy never deasserts.
- Wrap and saturation: 128 frames produce seq bytes 0x00..0x7F then 0x00. 300 dropped batches give dropped=255.
- Reset mid-frame: rst_n low during byte 5.
  - Required: tx_valid=0 immediately, dropped=0, no frame_done.
  - Required: next frame seq byte = 0x00.

Source files
------------

// File: rtl/count_frame_packer.sv
// count_frame_packer
//
// Packs one snapshot of the per-channel batch counters into a framed packet.
// The packet goes out byte by byte to a UART transmitter.
//
// Frame layout (NUM_CH+3 bytes):
//   0            : SYNC_BYTE
//   1            : {ovr, seq[6:0]}
//   2..NUM_CH+1  : shadow[0..NUM_CH-1]   (channel order A,B,BP,AP,AB,ABP,APB,APBP,ABBP)
//   NUM_CH+2     : XOR of bytes 1..NUM_CH+1
//
// Byte handshake: a byte moves on a rising clk edge where tx_valid=1 and
// tx_ready=1. Once tx_valid is raised it stays high until the last byte of the
// frame has moved. tx_data does not change while tx_valid=1 and tx_ready=0.
// tx_ready has no effect while tx_valid=0.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   batch_done in   single-cycle pulse, counts valid this cycle
//   counts     in   NUM_CH*8 flat count bus, channel k at [k*8 +: 8]
//   tx_ready   in   transmitter accepts a byte this cycle
//   tx_valid   out  tx_data holds a byte to send
//   tx_data    out  frame byte
//   busy       out  frame in progress (FSM in SEND)
//   frame_done out  one-cycle pulse after the checksum byte is accepted
//   dropped    out  saturating count of batches discarded during a frame
module count_frame_packer #(
   parameter int          NUM_CH    = 9,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  batch_done,
   input  logic [NUM_CH*8-1:0]   counts,
   input  logic                  tx_ready,
   output logic                  tx_valid,
   output logic [7:0]            tx_data,
   output logic                  busy,
   output logic                  frame_done,
   output logic [7:0]            dropped
);

   localparam int FRAME_LEN = NUM_CH + 3;
   localparam int IDXW      = $clog2(FRAME_LEN);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_LEN - 1);
   localparam logic [IDXW-1:0] HDR_IDX  = IDXW'(1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [IDXW-1:0]   idx;          // index of the byte currently in tx_data
   logic [IDXW-1:0]   idx_nxt;
   logic [7:0]        shadow [NUM_CH];
   logic [6:0]        seq;          // sequence number of the next frame
   logic              ovr_pend;     // a batch was dropped since the last snapshot
   logic [7:0]        hdr;          // {ovr, seq} latched with the snapshot
   logic [7:0]        chk;          // running XOR of bytes issued so far
   logic [7:0]        next_byte;

   logic              xfer;
   logic              last_xfer;
   logic              capture;
   logic              drop;
   logic [6:0]        seq_cur;

   // FSM state is visible externally as busy/tx_valid.
   assign tx_valid = (state == SEND);
   assign busy     = (state == SEND);

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and control strobes
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      xfer      = 1'b0;
      last_xfer = 1'b0;
      capture   = 1'b0;
      drop      = 1'b0;
      idx_nxt   = idx + IDXW'(1);

      case (state)
         IDLE: begin
            if (batch_done) begin
               capture   = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            xfer      = tx_ready;
            last_xfer = tx_ready && (idx == LAST_IDX);
            if (last_xfer) begin
               // A batch arriving together with the checksum handshake starts
               // the next frame straight away instead of being dropped.
               if (batch_done) begin
                  capture   = 1'b1;
                  state_nxt = SEND;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (batch_done) begin
               drop = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // The sequence number to stamp into a snapshot taken this cycle. It
   // already counts the frame whose checksum is accepted this cycle.
   assign seq_cur = last_xfer ? (seq + 7'd1) : seq;

   // ---------------------------------------------------------------------
   // Byte selection for the following byte (idx_nxt)
   // ---------------------------------------------------------------------
   always_comb begin
      next_byte = 8'h00;
      if (idx_nxt == HDR_IDX) begin
         next_byte = hdr;
      end else if (idx_nxt == LAST_IDX) begin
         next_byte = chk;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (idx_nxt == IDXW'(k + 2)) begin
               next_byte = shadow[k];
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Datapath: snapshot, byte sequencing, checksum
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         tx_data <= 8'h00;
         chk     <= 8'h00;
         hdr     <= 8'h00;
         for (int k = 0; k < NUM_CH; k++) begin
            shadow[k] <= 8'h00;
         end
      end else if (capture) begin
         for (int k = 0; k < NUM_CH; k++) begin
            shadow[k] <= counts[k*8 +: 8];
         end
         hdr     <= {ovr_pend, seq_cur};
         idx     <= '0;
         tx_data <= SYNC_BYTE;
         chk     <= 8'h00;
      end else if (last_xfer) begin
         idx     <= '0;
         tx_data <= 8'h00;
      end else if (xfer) begin
         idx     <= idx_nxt;
         tx_data <= next_byte;
         // The checksum is folded in as each covered byte is issued, so it is
         // complete by the time the checksum byte itself is loaded.
         if (idx_nxt != LAST_IDX) begin
            chk <= chk ^ next_byte;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Sequence, overrun bookkeeping, frame_done
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq        <= 7'd0;
         ovr_pend   <= 1'b0;
         frame_done <= 1'b0;
         dropped    <= 8'h00;
      end else begin
         frame_done <= last_xfer;

         if (last_xfer) begin
            seq <= seq + 7'd1;   // wraps 127 -> 0
         end

         // The pending flag moves into the header at snapshot time; drops and
         // snapshots never happen in the same cycle.
         if (capture) begin
            ovr_pend <= 1'b0;
         end else if (drop) begin
            ovr_pend <= 1'b1;
         end

         if (drop && (dropped != 8'hFF)) begin
            dropped <= dropped + 8'd1;
         end
      end
   end

endmodule
